// File: rtl/palindrome_pkg.sv
// Shared types and constants for the palindrome framing/checking blocks.
package palindrome_pkg;

    // Output-side occupancy of the framer.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } framer_state_t;

    // Width of the optional word/palindrome statistics counters.
    localparam int PAL_STAT_W = 16;

endpackage : palindrome_pkg

// File: rtl/palindrome_mirror_cmp.sv
// Combinational mirror comparator: match is 1 when word reads the same from
// both ends. Bit i is compared with bit DATA_WIDTH-1-i; the centre bit of an
// odd-width word has no partner and does not affect the result.
module palindrome_mirror_cmp
    import palindrome_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    output logic                  match
);

    // AND together the equality of every mirrored bit pair.
    always_comb begin
        match = 1'b1;
        for (int i = 0; i < DATA_WIDTH / 2; i++) begin
            match = match & (word[i] == word[DATA_WIDTH-1-i]);
        end
    end

endmodule : palindrome_mirror_cmp

// File: rtl/serial_palindrome_framer.sv
// Serial-to-word framer with palindrome flag.
// Collects DATA_WIDTH accepted bits into a word, registers the word together
// with its palindrome flag and offers both on a valid/ready output. While a
// word is held, the next word keeps collecting until its final bit, which is
// stalled only if the held word has still not been taken.
// Optional build macro: PAL_FRAMER_STATS_EN adds saturating word_cnt/pal_cnt
// counters of output transfers (pal_cnt only for palindromic words).
module serial_palindrome_framer
    import palindrome_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_word,
    output logic                  dout_pal,
    output logic                  dout_valid,
    input  logic                  dout_ready
`ifdef PAL_FRAMER_STATS_EN
    ,
    output logic [PAL_STAT_W-1:0] word_cnt,
    output logic [PAL_STAT_W-1:0] pal_cnt
`endif
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    framer_state_t             state_r;
    framer_state_t             state_nx_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [DATA_WIDTH-1:0]     sr_r;
    logic [DATA_WIDTH-1:0]     shifted_s;
    logic [DATA_WIDTH-1:0]     dout_word_r;
    logic                      dout_pal_r;
    logic                      pal_s;
    logic                      last_bit_s;
    logic                      din_ready_s;
    logic                      accept_s;
    logic                      complete_s;

    assign last_bit_s  = (cnt_r == CNT_LAST);
    // Only the word-completing bit must wait for the held word to drain.
    assign din_ready_s = !(last_bit_s && (state_r == ST_FULL) && !dout_ready);
    assign accept_s    = din_valid && din_ready_s;
    assign complete_s  = accept_s && last_bit_s;

    // Shift register value after taking the current bit, in the selected bit order.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {sr_r[DATA_WIDTH-2:0], din};
        end else begin
            shifted_s = {din, sr_r[DATA_WIDTH-1:1]};
        end
    end

    palindrome_mirror_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mirror_cmp (
        .word  (shifted_s),
        .match (pal_s)
    );

    // Output occupancy: a completion always (re)fills, otherwise a transfer empties.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (complete_s) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (complete_s) begin
                    state_nx_s = ST_FULL;
                end else if (dout_ready) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: begin
                state_nx_s = ST_EMPTY;
            end
        endcase
    end

    // State, bit counter, shift register and output word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            cnt_r       <= {CNT_W{1'b0}};
            sr_r        <= {DATA_WIDTH{1'b0}};
            dout_word_r <= {DATA_WIDTH{1'b0}};
            dout_pal_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                sr_r <= shifted_s;
                if (last_bit_s) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
            if (complete_s) begin
                dout_word_r <= shifted_s;
                dout_pal_r  <= pal_s;
            end
        end
    end

    assign din_ready  = din_ready_s;
    assign dout_word  = dout_word_r;
    assign dout_pal   = dout_pal_r;
    assign dout_valid = (state_r == ST_FULL);

`ifdef PAL_FRAMER_STATS_EN
    logic [PAL_STAT_W-1:0] word_cnt_r;
    logic [PAL_STAT_W-1:0] pal_cnt_r;
    logic                  xfer_s;

    // Saturating increment for the statistics counters.
    function automatic logic [PAL_STAT_W-1:0] sat_inc(input logic [PAL_STAT_W-1:0] v);
        logic [PAL_STAT_W-1:0] r;
        if (v == {PAL_STAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + PAL_STAT_W'(1);
        end
        return r;
    endfunction

    assign xfer_s = (state_r == ST_FULL) && dout_ready;

    // Count output transfers and the palindromic ones among them.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_r <= {PAL_STAT_W{1'b0}};
            pal_cnt_r  <= {PAL_STAT_W{1'b0}};
        end else if (xfer_s) begin
            word_cnt_r <= sat_inc(word_cnt_r);
            if (dout_pal_r) begin
                pal_cnt_r <= sat_inc(pal_cnt_r);
            end
        end
    end

    assign word_cnt = word_cnt_r;
    assign pal_cnt  = pal_cnt_r;
`endif

endmodule : serial_palindrome_framer
